// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: states, opcodes, mux selects
// and the packed control word driven onto the datapath.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       illegal_op;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic opcode_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_known = 1'b1;
            default:                                       opcode_known = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction-register/memory inputs and datapath control outputs of the controller.
interface multicycle_controller_if;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;
    logic       PCWrite;
    logic       Branch;
    logic       IllegalOp;
    logic       InstrDone;
    logic [3:0] State;

    modport master (
        output Opcode, mem_ready,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp, InstrDone, State
    );

    modport slave (
        input  Opcode, mem_ready,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
               ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp, InstrDone, State
    );
endinterface

// File: rtl/mc_output_decode.sv
// Combinational control-word decode from the current state; mem_ready and the
// opcode only shape the handshake and illegal-opcode outputs.
module mc_output_decode
    import mc_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    input  logic [5:0] i_opcode,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_IDLE;
        case (i_state)
            S_FETCH: begin
                o_ctrl.iord      = 1'b0;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_src    = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
                // Unknown opcodes retire here so the fetch loop never wedges
                o_ctrl.illegal_op = ~opcode_known(i_opcode);
                o_ctrl.instr_done = ~opcode_known(i_opcode);
            end
            S_MEMADR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.iord = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.iord       = 1'b1;
                o_ctrl.mem_write  = 1'b1;
                o_ctrl.instr_done = i_mem_ready;
            end
            S_RTYPEEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                o_ctrl.reg_dst    = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                o_ctrl.alu_src_a  = 1'b1;
                o_ctrl.alu_src_b  = SRCB_REG;
                o_ctrl.alu_op     = ALUOP_SUB;
                o_ctrl.pc_src     = PCSRC_ALUOUT;
                o_ctrl.branch     = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                o_ctrl.reg_dst    = 1'b0;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            S_JEX: begin
                o_ctrl.pc_src     = PCSRC_JUMP;
                o_ctrl.pc_write   = 1'b1;
                o_ctrl.instr_done = 1'b1;
            end
            default: o_ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle datapath sequencer: state register, next-state logic and reset
// gating of the control word.
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4 when memory completes
// DECODE    | read registers, precompute branch target, dispatch on opcode
// MEMADR    | base + offset address for lw/sw
// MEMRD     | memory read at ALUOut, waits for mem_ready
// MEMWB     | load data written to rt
// MEMWR     | memory write at ALUOut, waits for mem_ready
// RTYPEEX   | ALU operates on A,B per funct
// RTYPEWB   | ALU result written to rd
// BEQEX     | compare A,B; branch target taken on Zero
// ADDIEX    | A + sign-extended immediate
// ADDIWB    | ALU result written to rt
// JEX       | PC loaded with jump target
module multicycle_controller
    import mc_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    multicycle_controller_if.slave  bus
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    ctrl_t  w_ctrl_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_RTYPEWB: w_next = S_FETCH;
            S_BEQEX:   w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JEX:     w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    mc_output_decode u_output_decode (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .i_opcode    (bus.Opcode),
        .o_ctrl      (w_ctrl)
    );

    // FETCH would otherwise raise IRWrite/PCWrite from mem_ready during reset
    assign w_ctrl_out = reset_n ? w_ctrl : CTRL_IDLE;

    assign bus.IorD      = w_ctrl_out.iord;
    assign bus.MemWrite  = w_ctrl_out.mem_write;
    assign bus.IRWrite   = w_ctrl_out.ir_write;
    assign bus.RegDst    = w_ctrl_out.reg_dst;
    assign bus.MemtoReg  = w_ctrl_out.mem_to_reg;
    assign bus.RegWrite  = w_ctrl_out.reg_write;
    assign bus.ALUSrcA   = w_ctrl_out.alu_src_a;
    assign bus.ALUSrcB   = w_ctrl_out.alu_src_b;
    assign bus.ALUOp     = w_ctrl_out.alu_op;
    assign bus.PCSrc     = w_ctrl_out.pc_src;
    assign bus.PCWrite   = w_ctrl_out.pc_write;
    assign bus.Branch    = w_ctrl_out.branch;
    assign bus.IllegalOp = w_ctrl_out.illegal_op;
    assign bus.InstrDone = w_ctrl_out.instr_done;
    assign bus.State     = reset_n ? r_state : 4'd0;

endmodule
